imem_uart_loader: RTL and testbench

IMEM_UART_LOADER -- requirements
Module: imem_uart_loader

---
 rtl/imem_uart_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// Boot loader: receives 8N1 UART bytes (word count, then big-endian words) and writes them to instruction RAM.
// The CPU is held in reset-like stall until the whole image has been written without error.
module imem_uart_loader #(
   parameter int BAUD_DIV  = 5208,
   parameter int MAX_WORDS = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        uart_rx,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err
);

   localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
   localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {HDR, DATA, DONE, ERR} state_t;

   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   rx_state_t   rx_state_q;
   logic [15:0] baud_cnt_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  shift_q;
   logic        byte_vld_q;
   logic        frame_err_q;

   state_t      state_q;
   logic [7:0]  count_q;
   logic [7:0]  index_q;
   logic [1:0]  byte_cnt_q;
   logic [23:0] asm_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        hold_q;
   logic        done_q;
   logic        err_q;

   // rx_prev_q is the previous synchronized sample, used only for start-edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= uart_rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state_q  <= RX_IDLE;
         baud_cnt_q  <= 16'd0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         byte_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         byte_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_prev_q && !rx_s2_q) begin
                  rx_state_q <= RX_START;
                  baud_cnt_q <= 16'd0;
               end
            end
            RX_START: begin
               if (baud_cnt_q == HALF_LAST) begin
                  baud_cnt_q <= 16'd0;
                  bit_cnt_q  <= 3'd0;
                  rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            RX_DATA: begin
               if (baud_cnt_q == BIT_LAST) begin
                  baud_cnt_q <= 16'd0;
                  shift_q    <= {rx_s2_q, shift_q[7:1]};
                  bit_cnt_q  <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rx_state_q <= RX_STOP;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            RX_STOP: begin
               if (baud_cnt_q == BIT_LAST) begin
                  baud_cnt_q  <= 16'd0;
                  byte_vld_q  <= rx_s2_q;
                  frame_err_q <= !rx_s2_q;
                  rx_state_q  <= RX_IDLE;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= HDR;
         count_q    <= 8'd0;
         index_q    <= 8'd0;
         byte_cnt_q <= 2'd0;
         asm_q      <= 24'd0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            HDR: begin
               if (frame_err_q) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end else if (byte_vld_q) begin
                  count_q    <= shift_q;
                  index_q    <= 8'd0;
                  byte_cnt_q <= 2'd0;
                  if (shift_q == 8'd0) begin
                     state_q <= DONE;
                     hold_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else if ({24'd0, shift_q} > 32'(MAX_WORDS)) begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               // Bytes are >= 10 bit times apart, so the write cycle never collides with a receive event
               if (we_q) begin
                  we_q    <= 1'b0;
                  index_q <= index_q + 8'd1;
                  if (index_q == count_q - 8'd1) begin
                     state_q <= DONE;
                     hold_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else if (frame_err_q) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end else if (byte_vld_q) begin
                  asm_q      <= {asm_q[15:0], shift_q};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     we_q    <= 1'b1;
                     wdata_q <= {asm_q, shift_q};
                     addr_q  <= {22'd0, index_q, 2'b00};
                  end
               end
            end
            default: we_q <= 1'b0;
         endcase
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign load_done  = done_q;
   assign load_err   = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: serial byte streams against a stream-level model of the load protocol.
module tb_imem_uart_loader;

   localparam int BAUD = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        uart_rx;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;

   imem_uart_loader #(.BAUD_DIV(BAUD), .MAX_WORDS(128)) dut (
      .clk(clk), .reset(reset), .uart_rx(uart_rx),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [7:0]  tx_q[$];
   int          bad_idx;
   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];
   logic [2:0]  exp_flags;   // {cpu_hold, load_done, load_err}

   logic        prev_we = 1'b0;
   logic [31:0] last_a = 32'd0;
   logic [31:0] last_d = 32'd0;

   always @(negedge clk) begin
      if (reset) begin
         last_a  = 32'd0;
         last_d  = 32'd0;
         prev_we = 1'b0;
      end else begin
         if (imem_we) begin
            n_cmp++;
            if (prev_we) begin
               n_fail++;
               $display("FAIL we_pulse_width: imem_we high on consecutive cycles, addr=%h", imem_addr);
            end
            obs_q.push_back({imem_addr, imem_wdata});
            last_a = imem_addr;
            last_d = imem_wdata;
         end else begin
            n_cmp++;
            if (imem_addr !== last_a || imem_wdata !== last_d) begin
               n_fail++;
               $display("FAIL hold_when_idle: got addr=%h data=%h want addr=%h data=%h",
                        imem_addr, imem_wdata, last_a, last_d);
            end
         end
         n_cmp++;
         if (load_done && load_err) begin
            n_fail++;
            $display("FAIL done_err_exclusive: load_done=%b load_err=%b want not both 1", load_done, load_err);
         end
         prev_we = imem_we;
      end
   end

   // Stream-level model: header byte, then N big-endian words; any bad stop bit aborts
   task automatic model();
      int n;
      int idx;
      logic [31:0] word;
      exp_q.delete();
      exp_flags = 3'b100;
      if (tx_q.size() == 0) return;
      if (bad_idx == 0) begin exp_flags = 3'b101; return; end
      n = int'(tx_q[0]);
      if (n == 0) begin exp_flags = 3'b010; return; end
      if (n > 128) begin exp_flags = 3'b101; return; end
      for (int w = 0; w < n; w++) begin
         word = 32'd0;
         for (int b = 0; b < 4; b++) begin
            idx = 1 + 4 * w + b;
            if (idx >= tx_q.size()) return;
            if (idx == bad_idx) begin exp_flags = 3'b101; return; end
            word = {word[23:0], tx_q[idx]};
         end
         exp_q.push_back({32'(w * 4), word});
      end
      exp_flags = 3'b010;
   endtask

   task automatic bit_out(input logic v);
      @(negedge clk) uart_rx = v;
      repeat (BAUD - 1) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
      bit_out(stop_ok);
      @(negedge clk) uart_rx = 1'b1;
      repeat (2 * BAUD) @(negedge clk);
   endtask

   task automatic send_stream();
      foreach (tx_q[i]) send_byte(tx_q[i], (i != bad_idx));
      repeat (4 * BAUD) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      obs_q.delete();
      tx_q.delete();
      bad_idx = -1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", imem_we); end
      n_cmp++;
      if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      n_cmp++;
      if (imem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
      n_cmp++;
      if ({cpu_hold, load_done, load_err} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_flags: got hold/done/err=%b want 100", {cpu_hold, load_done, load_err});
      end
   endtask

   task automatic test_single();
      do_reset();
      tx_q = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h2F};
      send_stream();
      n_cmp++;
      if (obs_q.size() != 1) begin
         n_fail++; $display("FAIL single_count: got %0d writes want 1", obs_q.size());
      end else begin
         n_cmp++;
         if (obs_q[0] !== {32'h0, 32'h0800002F}) begin
            n_fail++; $display("FAIL single_word: got %h want 000000000800002f", obs_q[0]);
         end
      end
      n_cmp++;
      if ({cpu_hold, load_done, load_err} !== 3'b010) begin
         n_fail++; $display("FAIL single_flags: got %b want 010", {cpu_hold, load_done, load_err});
      end
   endtask

   // Random image with trailing bytes that must be ignored once DONE
   task automatic test_multi(input int n);
      do_reset();
      tx_q.push_back(8'(n));
      repeat (4 * n + 4) tx_q.push_back(8'($urandom_range(0, 255)));
      model();
      send_stream();
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL multi_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         if (i < obs_q.size()) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL multi_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
      n_cmp++;
      if ({cpu_hold, load_done, load_err} !== exp_flags) begin
         n_fail++; $display("FAIL multi_flags: got %b want %b", {cpu_hold, load_done, load_err}, exp_flags);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      tx_q.push_back(8'($urandom_range(129, 255)));
      repeat (4) tx_q.push_back(8'($urandom_range(0, 255)));
      model();
      send_stream();
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL overflow_writes: got %0d writes want 0", obs_q.size());
      end
      n_cmp++;
      if ({cpu_hold, load_done, load_err} !== exp_flags) begin
         n_fail++; $display("FAIL overflow_flags: got %b want %b", {cpu_hold, load_done, load_err}, exp_flags);
      end
   endtask

   task automatic test_frame_err();
      do_reset();
      tx_q.push_back(8'h02);
      repeat (8) tx_q.push_back(8'($urandom_range(0, 255)));
      bad_idx = $urandom_range(5, 8);
      model();
      send_stream();
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL frame_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
      end else if (exp_q.size() > 0) begin
         n_cmp++;
         if (obs_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL frame_word0: got %h want %h", obs_q[0], exp_q[0]);
         end
      end
      n_cmp++;
      if ({cpu_hold, load_done, load_err} !== exp_flags) begin
         n_fail++; $display("FAIL frame_flags: got %b want %b", {cpu_hold, load_done, load_err}, exp_flags);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      @(negedge clk) uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * BAUD) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != 0 || {cpu_hold, load_done, load_err} !== 3'b100) begin
         n_fail++;
         $display("FAIL glitch_idle: got writes=%0d flags=%b want 0 and 100", obs_q.size(),
                  {cpu_hold, load_done, load_err});
      end
      tx_q.push_back(8'h01);
      repeat (4) tx_q.push_back(8'($urandom_range(0, 255)));
      model();
      send_stream();
      n_cmp++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
         n_fail++;
         $display("FAIL glitch_then_load: got writes=%0d first=%h want 1 and %h", obs_q.size(),
                  (obs_q.size() > 0) ? obs_q[0] : 64'd0, exp_q[0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b2;
      do_reset();
      send_byte(8'h01, 1'b1);
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      b2 = 8'($urandom_range(0, 255));
      bit_out(1'b0);
      for (int i = 0; i < 3; i++) bit_out(b2[i]);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({imem_we, cpu_hold, load_done, load_err} !== 4'b0100) begin
         n_fail++;
         $display("FAIL midreset_forced: got we/hold/done/err=%b want 0100",
                  {imem_we, cpu_hold, load_done, load_err});
      end
      uart_rx = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (2 * BAUD) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL midreset_nowrite: got %0d writes want 0", obs_q.size());
      end
      tx_q.delete();
      bad_idx = -1;
      tx_q.push_back(8'h01);
      repeat (4) tx_q.push_back(8'($urandom_range(0, 255)));
      model();
      send_stream();
      n_cmp++;
      if (obs_q.size() != 1) begin
         n_fail++; $display("FAIL midreset_count: got %0d writes want 1", obs_q.size());
      end else begin
         n_cmp++;
         if (obs_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL midreset_word: got %h want %h", obs_q[0], exp_q[0]);
         end
      end
      n_cmp++;
      if ({cpu_hold, load_done, load_err} !== 3'b010) begin
         n_fail++; $display("FAIL midreset_flags: got %b want 010", {cpu_hold, load_done, load_err});
      end
   endtask

   initial begin
      reset   = 1'b1;
      uart_rx = 1'b1;
      bad_idx = -1;
      test_reset();
      test_single();
      test_multi(3);
      test_multi($urandom_range(2, 5));
      test_multi(0);
      test_overflow();
      test_frame_err();
      test_glitch();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
